// File: rtl/flash_pkg.sv
// Purpose: shared constants, widths and FSM encoding for the flash operation arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package flash_pkg;

    localparam int FLASH_ADDR_W = 24;
    localparam int FLASH_BNUM_W = 9;

    localparam logic [1:0] FLASH_OP_READ  = 2'd0;
    localparam logic [1:0] FLASH_OP_WRITE = 2'd1;
    localparam logic [1:0] FLASH_OP_ERASE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_GRANT     = 2'd1,
        ST_WAIT_LOW  = 2'd2,
        ST_WAIT_DONE = 2'd3
    } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Purpose: two-input round-robin pick; on a tie the requester that did not win last time wins.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module rr_arb2 (
    input  logic i_valid0,
    input  logic i_valid1,
    input  logic i_last_grant,
    output logic o_grant,
    output logic o_grant_valid
);

    // Tie goes to the requester opposite the last winner; otherwise the lone valid one.
    always_comb begin
        o_grant_valid = i_valid0 | i_valid1;
        if (i_valid0 && i_valid1) begin
            o_grant = ~i_last_grant;
        end else begin
            o_grant = i_valid1;
        end
    end

endmodule

// File: rtl/flash_op_arbiter.sv
// Purpose: gives one of two requesters exclusive use of the SPI flash driver from op handshake to completion.
// Latency: request seen in IDLE at cycle t is presented to the driver at t+1; completion/timeout pulses are combinational.
// Backpressure: driver ready is passed back only to the owner; the other requester is held off, never dropped.
module flash_op_arbiter
    import flash_pkg::*;
#(
    parameter int          P_DATA_WIDTH = 8,
    parameter logic [23:0] P_TIMEOUT    = 24'hFFFFFF
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,

    input  logic [1:0]              i_req0_op_type,
    input  logic [FLASH_ADDR_W-1:0] i_req0_op_addr,
    input  logic [FLASH_BNUM_W-1:0] i_req0_op_byte_num,
    input  logic                    i_req0_op_valid,
    output logic                    o_req0_op_ready,
    input  logic [P_DATA_WIDTH-1:0] i_req0_write_data,
    input  logic                    i_req0_write_sop,
    input  logic                    i_req0_write_eop,
    input  logic                    i_req0_write_valid,
    output logic [P_DATA_WIDTH-1:0] o_req0_read_data,
    output logic                    o_req0_read_sop,
    output logic                    o_req0_read_eop,
    output logic                    o_req0_read_valid,

    input  logic [1:0]              i_req1_op_type,
    input  logic [FLASH_ADDR_W-1:0] i_req1_op_addr,
    input  logic [FLASH_BNUM_W-1:0] i_req1_op_byte_num,
    input  logic                    i_req1_op_valid,
    output logic                    o_req1_op_ready,
    input  logic [P_DATA_WIDTH-1:0] i_req1_write_data,
    input  logic                    i_req1_write_sop,
    input  logic                    i_req1_write_eop,
    input  logic                    i_req1_write_valid,
    output logic [P_DATA_WIDTH-1:0] o_req1_read_data,
    output logic                    o_req1_read_sop,
    output logic                    o_req1_read_eop,
    output logic                    o_req1_read_valid,

    output logic [1:0]              o_operation_type,
    output logic [FLASH_ADDR_W-1:0] o_operation_addr,
    output logic [FLASH_BNUM_W-1:0] o_operation_byte_num,
    output logic                    o_operation_valid,
    input  logic                    i_operation_ready,

    output logic [P_DATA_WIDTH-1:0] o_write_data,
    output logic                    o_write_sop,
    output logic                    o_write_eop,
    output logic                    o_write_valid,

    input  logic [P_DATA_WIDTH-1:0] i_read_data,
    input  logic                    i_read_sop,
    input  logic                    i_read_eop,
    input  logic                    i_read_valid,

    output logic                    o_owner,
    output logic                    o_busy,
    output logic                    o_op_done,
    output logic                    o_timeout
);

    arb_state_e              state_q, state_d;
    logic                    owner_q, owner_d;
    logic                    last_grant_q, last_grant_d;
    logic [23:0]             cnt_q, cnt_d;

    logic                    arb_grant;
    logic                    arb_vld;
    logic                    cnt_expired;
    logic                    op_done;
    logic                    timeout;

    logic                    own_op_vld;
    logic [1:0]              own_type;
    logic [FLASH_ADDR_W-1:0] own_addr;
    logic [FLASH_BNUM_W-1:0] own_bnum;
    logic [P_DATA_WIDTH-1:0] own_wr_dat;
    logic                    own_wr_sop;
    logic                    own_wr_eop;
    logic                    own_wr_vld;

    rr_arb2 u_rr_arb2 (
        .i_valid0      (i_req0_op_valid),
        .i_valid1      (i_req1_op_valid),
        .i_last_grant  (last_grant_q),
        .o_grant       (arb_grant),
        .o_grant_valid (arb_vld)
    );

    assign cnt_expired = (cnt_q == (P_TIMEOUT - 24'd1));

    // Select the current owner's request fields and write stream.
    always_comb begin
        if (owner_q) begin
            own_op_vld = i_req1_op_valid;
            own_type   = i_req1_op_type;
            own_addr   = i_req1_op_addr;
            own_bnum   = i_req1_op_byte_num;
            own_wr_dat = i_req1_write_data;
            own_wr_sop = i_req1_write_sop;
            own_wr_eop = i_req1_write_eop;
            own_wr_vld = i_req1_write_valid;
        end else begin
            own_op_vld = i_req0_op_valid;
            own_type   = i_req0_op_type;
            own_addr   = i_req0_op_addr;
            own_bnum   = i_req0_op_byte_num;
            own_wr_dat = i_req0_write_data;
            own_wr_sop = i_req0_write_sop;
            own_wr_eop = i_req0_write_eop;
            own_wr_vld = i_req0_write_valid;
        end
    end

    // FSM, owner, round-robin history and watchdog registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
        end
    end

    // Next-state: grant, hand off to the driver, track ready low/high, watchdog.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        op_done      = 1'b0;
        timeout      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arb_vld) begin
                    owner_d = arb_grant;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (own_op_vld && i_operation_ready) begin
                    state_d = ST_WAIT_LOW;
                    cnt_d   = '0;
                end else if (!own_op_vld) begin
                    // Owner withdrew before acceptance: no history update.
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_LOW, ST_WAIT_DONE: begin
                cnt_d = cnt_q + 24'd1;
                // Completion is checked first so it wins over a same-cycle expiry.
                if ((state_q == ST_WAIT_DONE) && i_operation_ready) begin
                    op_done      = 1'b1;
                    state_d      = ST_IDLE;
                    last_grant_d = owner_q;
                    cnt_d        = '0;
                end else if (cnt_expired) begin
                    timeout      = 1'b1;
                    state_d      = ST_IDLE;
                    last_grant_d = owner_q;
                    cnt_d        = '0;
                end else if ((state_q == ST_WAIT_LOW) && !i_operation_ready) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Route op handshake, write stream and read strobes to/from the owner only.
    always_comb begin
        o_operation_valid    = 1'b0;
        o_operation_type     = '0;
        o_operation_addr     = '0;
        o_operation_byte_num = '0;
        o_req0_op_ready      = 1'b0;
        o_req1_op_ready      = 1'b0;
        o_write_data         = '0;
        o_write_sop          = 1'b0;
        o_write_eop          = 1'b0;
        o_write_valid        = 1'b0;
        o_req0_read_data     = i_read_data;
        o_req1_read_data     = i_read_data;
        o_req0_read_sop      = 1'b0;
        o_req0_read_eop      = 1'b0;
        o_req0_read_valid    = 1'b0;
        o_req1_read_sop      = 1'b0;
        o_req1_read_eop      = 1'b0;
        o_req1_read_valid    = 1'b0;
        if (state_q == ST_GRANT) begin
            o_operation_valid    = own_op_vld;
            o_operation_type     = own_type;
            o_operation_addr     = own_addr;
            o_operation_byte_num = own_bnum;
            o_req0_op_ready      = !owner_q && own_op_vld && i_operation_ready;
            o_req1_op_ready      =  owner_q && own_op_vld && i_operation_ready;
        end
        if (state_q != ST_IDLE) begin
            o_write_data  = own_wr_dat;
            o_write_sop   = own_wr_sop;
            o_write_eop   = own_wr_eop;
            o_write_valid = own_wr_vld;
        end
        if ((state_q == ST_WAIT_LOW) || (state_q == ST_WAIT_DONE)) begin
            if (owner_q) begin
                o_req1_read_sop   = i_read_sop;
                o_req1_read_eop   = i_read_eop;
                o_req1_read_valid = i_read_valid;
            end else begin
                o_req0_read_sop   = i_read_sop;
                o_req0_read_eop   = i_read_eop;
                o_req0_read_valid = i_read_valid;
            end
        end
    end

    assign o_owner   = owner_q;
    assign o_busy    = (state_q != ST_IDLE);
    assign o_op_done = op_done;
    assign o_timeout = timeout;

endmodule

// File: tb/tb_flash_op_arbiter.sv
// Purpose: two arbiter instances (long and short watchdog) driven in lockstep against a reference model.
// Latency: checks sampled 1 ns after each falling edge; stimulus changes on falling edges.
// Backpressure: a small driver model drops ready after each accept and raises it after a set delay.
module tb_flash_op_arbiter;
    import flash_pkg::*;

    localparam int DW = 8;

    logic i_clk = 1'b0;
    logic i_rst_n;
    always #100 i_clk = ~i_clk;

    logic [1:0]  rq_type [2];
    logic [23:0] rq_addr [2];
    logic [8:0]  rq_bn   [2];
    logic        rq_vld  [2];
    logic [7:0]  wr_dat  [2];
    logic        wr_sop  [2];
    logic        wr_eop  [2];
    logic        wr_vld  [2];
    logic        drv_rdy;
    logic [7:0]  rd_dat;
    logic        rd_sop, rd_eop, rd_vld;

    logic        op_rdy_o [2][2];
    logic [7:0]  rdd_o    [2][2];
    logic        rds_o    [2][2];
    logic        rde_o    [2][2];
    logic        rdv_o    [2][2];
    logic [1:0]  ot_o     [2];
    logic [23:0] oa_o     [2];
    logic [8:0]  ob_o     [2];
    logic        ov_o     [2];
    logic [7:0]  wd_o     [2];
    logic        ws_o     [2];
    logic        we_o     [2];
    logic        wv_o     [2];
    logic        own_o    [2];
    logic        busy_o   [2];
    logic        done_o   [2];
    logic        to_o     [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        flash_op_arbiter #(
            .P_DATA_WIDTH (DW),
            .P_TIMEOUT    ((g == 0) ? 24'd64 : 24'd16)
        ) u_dut (
            .i_clk                (i_clk),
            .i_rst_n              (i_rst_n),
            .i_req0_op_type       (rq_type[0]),
            .i_req0_op_addr       (rq_addr[0]),
            .i_req0_op_byte_num   (rq_bn[0]),
            .i_req0_op_valid      (rq_vld[0]),
            .o_req0_op_ready      (op_rdy_o[g][0]),
            .i_req0_write_data    (wr_dat[0]),
            .i_req0_write_sop     (wr_sop[0]),
            .i_req0_write_eop     (wr_eop[0]),
            .i_req0_write_valid   (wr_vld[0]),
            .o_req0_read_data     (rdd_o[g][0]),
            .o_req0_read_sop      (rds_o[g][0]),
            .o_req0_read_eop      (rde_o[g][0]),
            .o_req0_read_valid    (rdv_o[g][0]),
            .i_req1_op_type       (rq_type[1]),
            .i_req1_op_addr       (rq_addr[1]),
            .i_req1_op_byte_num   (rq_bn[1]),
            .i_req1_op_valid      (rq_vld[1]),
            .o_req1_op_ready      (op_rdy_o[g][1]),
            .i_req1_write_data    (wr_dat[1]),
            .i_req1_write_sop     (wr_sop[1]),
            .i_req1_write_eop     (wr_eop[1]),
            .i_req1_write_valid   (wr_vld[1]),
            .o_req1_read_data     (rdd_o[g][1]),
            .o_req1_read_sop      (rds_o[g][1]),
            .o_req1_read_eop      (rde_o[g][1]),
            .o_req1_read_valid    (rdv_o[g][1]),
            .o_operation_type     (ot_o[g]),
            .o_operation_addr     (oa_o[g]),
            .o_operation_byte_num (ob_o[g]),
            .o_operation_valid    (ov_o[g]),
            .i_operation_ready    (drv_rdy),
            .o_write_data         (wd_o[g]),
            .o_write_sop          (ws_o[g]),
            .o_write_eop          (we_o[g]),
            .o_write_valid        (wv_o[g]),
            .i_read_data          (rd_dat),
            .i_read_sop           (rd_sop),
            .i_read_eop           (rd_eop),
            .i_read_valid         (rd_vld),
            .o_owner              (own_o[g]),
            .o_busy               (busy_o[g]),
            .o_op_done            (done_o[g]),
            .o_timeout            (to_o[g])
        );
    end

    int n_chk = 0;
    int n_err = 0;
    int obs_done [2];
    int obs_to   [2];
    int drv_delay;
    int drv_cnt;
    bit rnd;

    // Reference model, per instance: is someone granted, has the driver taken the op,
    // has ready been seen low since, how many wait cycles have elapsed.
    bit m_act  [2];
    bit m_acc  [2];
    bit m_low  [2];
    bit m_own  [2];
    bit m_last [2];
    int m_age  [2];

    function automatic int tlim(input int i);
        return (i == 0) ? 64 : 16;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_init();
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 0; m_acc[i] = 0; m_low[i] = 0;
            m_own[i] = 0; m_last[i] = 1; m_age[i] = 0;
        end
    endtask

    task automatic model_update(input int i);
        bit o;
        o = m_own[i];
        if (!m_act[i]) begin
            if (rq_vld[0] || rq_vld[1]) begin
                m_act[i] = 1;
                m_acc[i] = 0;
                m_own[i] = (rq_vld[0] && rq_vld[1]) ? !m_last[i] : rq_vld[1];
            end
        end else if (!m_acc[i]) begin
            if (rq_vld[o] && drv_rdy) begin
                m_acc[i] = 1; m_low[i] = 0; m_age[i] = 0;
            end else if (!rq_vld[o]) begin
                m_act[i] = 0;
            end
        end else if ((m_low[i] && drv_rdy) || (m_age[i] == tlim(i) - 1)) begin
            m_act[i] = 0; m_acc[i] = 0; m_last[i] = o;
        end else begin
            if (!drv_rdy) m_low[i] = 1;
            m_age[i]++;
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            bit o, grant, wph, ov, done, tmo;
            o     = m_own[i];
            grant = m_act[i] && !m_acc[i];
            wph   = m_acc[i];
            ov    = grant && rq_vld[o];
            done  = wph && m_low[i] && drv_rdy;
            tmo   = wph && !done && (m_age[i] == tlim(i) - 1);
            check($sformatf("ctrl%0d", i),
                  64'({busy_o[i], own_o[i], ov_o[i], op_rdy_o[i][0], op_rdy_o[i][1], done_o[i], to_o[i]}),
                  64'({m_act[i], o, ov, ov && drv_rdy && !o, ov && drv_rdy && o, done, tmo}));
            check($sformatf("fields%0d", i), 64'({ot_o[i], oa_o[i], ob_o[i]}),
                  64'(grant ? {rq_type[o], rq_addr[o], rq_bn[o]} : 35'd0));
            check($sformatf("wr%0d", i), 64'({wv_o[i], ws_o[i], we_o[i], wd_o[i]}),
                  64'(m_act[i] ? {wr_vld[o], wr_sop[o], wr_eop[o], wr_dat[o]} : 11'd0));
            check($sformatf("rd%0d", i),
                  64'({rdv_o[i][0], rds_o[i][0], rde_o[i][0], rdv_o[i][1], rds_o[i][1], rde_o[i][1],
                       rdd_o[i][0], rdd_o[i][1]}),
                  64'({(wph && !o) ? {rd_vld, rd_sop, rd_eop} : 3'b000,
                       (wph &&  o) ? {rd_vld, rd_sop, rd_eop} : 3'b000, rd_dat, rd_dat}));
            obs_done[i] += int'(done_o[i]);
            obs_to[i]   += int'(to_o[i]);
        end
    endtask

    // One clock: check outputs, advance models at the edge, then requester/driver reactions.
    task automatic step();
        bit acc [2];
        #1;
        check_all();
        @(posedge i_clk);
        for (int n = 0; n < 2; n++)
            acc[n] = m_act[0] && !m_acc[0] && (int'(m_own[0]) == n) && rq_vld[n] && drv_rdy;
        model_update(0);
        model_update(1);
        @(negedge i_clk);
        for (int n = 0; n < 2; n++)
            if (acc[n]) rq_vld[n] = 1'b0;
        if (acc[0] || acc[1]) begin
            if (rnd) drv_delay = ($urandom_range(0, 9) == 0) ? 80 : int'($urandom_range(1, 25));
            drv_rdy = 1'b0;
            drv_cnt = drv_delay;
        end else if (!drv_rdy && drv_cnt > 0) begin
            drv_cnt--;
            if (drv_cnt == 0) drv_rdy = 1'b1;
        end
        if (rnd) begin
            for (int n = 0; n < 2; n++) begin
                if (!rq_vld[n] && $urandom_range(0, 3) == 0) begin
                    rq_vld[n]  = 1'b1;
                    rq_type[n] = 2'($urandom_range(0, 2));
                    rq_addr[n] = 24'($urandom);
                    rq_bn[n]   = 9'($urandom);
                end else if (rq_vld[n] && $urandom_range(0, 49) == 0) begin
                    rq_vld[n] = 1'b0;
                end
                wr_vld[n] = 1'($urandom); wr_sop[n] = 1'($urandom);
                wr_eop[n] = 1'($urandom); wr_dat[n] = 8'($urandom);
            end
            rd_vld = 1'($urandom); rd_sop = 1'($urandom);
            rd_eop = 1'($urandom); rd_dat = 8'($urandom);
        end
    endtask

    task automatic clear_inputs();
        for (int n = 0; n < 2; n++) begin
            rq_type[n] = '0; rq_addr[n] = '0; rq_bn[n] = '0; rq_vld[n] = 1'b0;
            wr_dat[n] = '0; wr_sop[n] = 1'b0; wr_eop[n] = 1'b0; wr_vld[n] = 1'b0;
        end
        rd_dat = '0; rd_sop = 1'b0; rd_eop = 1'b0; rd_vld = 1'b0;
        drv_rdy = 1'b1; drv_cnt = 0;
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s_ctl%0d", tag, i),
                  64'({busy_o[i], own_o[i], ov_o[i], done_o[i], to_o[i], op_rdy_o[i][0], op_rdy_o[i][1],
                       ot_o[i], oa_o[i], ob_o[i]}), 64'd0);
            check($sformatf("%s_str%0d", tag, i),
                  64'({wd_o[i], ws_o[i], we_o[i], wv_o[i], rdd_o[i][0], rds_o[i][0], rde_o[i][0], rdv_o[i][0],
                       rdd_o[i][1], rds_o[i][1], rde_o[i][1], rdv_o[i][1]}), 64'd0);
        end
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rst_n = 1'b0;
        clear_inputs();
        model_init();
        #1;
        check_all_zero("reset");
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    task automatic wait_accept(input string tag, output bit own, output bit ok);
        own = 1'b0;
        ok  = 1'b0;
        for (int k = 0; k < 60 && !ok; k++) begin
            #1;
            if (ov_o[0] && drv_rdy) begin
                own = own_o[0];
                ok  = 1'b1;
            end
            step();
        end
        check({tag, "_accept"}, 64'(ok), 64'd1);
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 150 && !ok; k++) begin
            #1;
            if (!busy_o[0]) ok = 1'b1;
            else step();
        end
        check({tag, "_idle"}, 64'(ok), 64'd1);
    endtask

    logic [7:0] beat [4];
    bit         own, ok;
    int         tc;

    initial begin
        i_rst_n = 1'b0;
        rnd = 1'b0;
        drv_delay = 3;
        clear_inputs();
        model_init();
        beat[0] = 8'hA5; beat[1] = 8'h5A; beat[2] = 8'h3C; beat[3] = 8'hC3;

        // Single erase from requester 0, driver busy for 20 cycles.
        do_reset();
        rq_type[0] = FLASH_OP_ERASE; rq_addr[0] = 24'h001000; rq_bn[0] = 9'd0; rq_vld[0] = 1'b1;
        drv_delay = 20;
        obs_done[0] = 0;
        step();
        #1;
        check("t1_opvalid_next", 64'(ov_o[0]), 64'd1);
        check("t1_addr", 64'(oa_o[0]), 64'h001000);
        repeat (40) step();
        check("t1_done_count", 64'(obs_done[0]), 64'd1);
        #1;
        check("t1_owner", 64'(own_o[0]), 64'd0);
        check("t1_busy", 64'(busy_o[0]), 64'd0);

        // Both requesters valid together, three rounds: grants must alternate.
        do_reset();
        drv_delay = 3;
        rq_type[1] = FLASH_OP_READ; rq_addr[1] = 24'h000200; rq_bn[1] = 9'd4;
        for (int r = 0; r < 3; r++) begin
            rq_type[0] = FLASH_OP_WRITE; rq_addr[0] = 24'h000300; rq_bn[0] = 9'd2;
            rq_vld[0] = 1'b1; rq_vld[1] = 1'b1;
            wait_accept("t2", own, ok);
            check($sformatf("t2_grant_r%0d", r), 64'(own), 64'(r % 2));
            wait_idle("t2");
        end

        // Requester 1 read with requester 0 still waiting; read strobes only to requester 1.
        rq_vld[0] = 1'b1;
        drv_delay = 10;
        wait_accept("t3", own, ok);
        check("t3_owner", 64'(own), 64'd1);
        for (int b = 0; b < 4; b++) begin
            rd_vld = 1'b1; rd_dat = beat[b]; rd_sop = (b == 0); rd_eop = (b == 3);
            #1;
            check("t3_req1_rd", 64'({rdv_o[0][1], rds_o[0][1], rde_o[0][1], rdd_o[0][1]}),
                  64'({1'b1, b == 0, b == 3, beat[b]}));
            check("t3_req0_rdv", 64'(rdv_o[0][0]), 64'd0);
            step();
        end
        rd_vld = 1'b0; rd_sop = 1'b0; rd_eop = 1'b0; rd_dat = '0;
        wait_idle("t3");

        // Requester 0 page write while requester 1 pushes 0xFF on its write port.
        wait_accept("t4", own, ok);
        check("t4_owner", 64'(own), 64'd0);
        wr_vld[1] = 1'b1; wr_dat[1] = 8'hFF; wr_sop[1] = 1'b1; wr_eop[1] = 1'b1;
        wr_vld[0] = 1'b1; wr_dat[0] = 8'h11; wr_sop[0] = 1'b1; wr_eop[0] = 1'b0;
        #1;
        check("t4_wr_b0", 64'({wv_o[0], ws_o[0], we_o[0], wd_o[0]}), 64'({3'b110, 8'h11}));
        step();
        wr_dat[0] = 8'h22; wr_sop[0] = 1'b0; wr_eop[0] = 1'b1;
        #1;
        check("t4_wr_b1", 64'({wv_o[0], ws_o[0], we_o[0], wd_o[0]}), 64'({3'b101, 8'h22}));
        step();
        wr_vld[0] = 1'b0; wr_sop[0] = 1'b0; wr_eop[0] = 1'b0;
        #1;
        check("t4_wr_other", 64'(wv_o[0]), 64'd0);
        step();
        wr_vld[1] = 1'b0; wr_sop[1] = 1'b0; wr_eop[1] = 1'b0;
        wait_idle("t4");

        // Driver never raises ready: short-watchdog instance expires and moves to requester 1.
        do_reset();
        drv_delay = -1;
        rq_type[0] = FLASH_OP_ERASE; rq_addr[0] = 24'h020000; rq_vld[0] = 1'b1;
        rq_type[1] = FLASH_OP_READ;  rq_addr[1] = 24'h000040; rq_bn[1] = 9'd8; rq_vld[1] = 1'b1;
        wait_accept("t5", own, ok);
        tc = 0;
        for (int k = 1; k <= 40 && tc == 0; k++) begin
            #1;
            if (to_o[1]) tc = k;
            step();
        end
        check("t5_timeout_cycle", 64'(tc), 64'd16);
        #1;
        check("t5_idle_after_to", 64'(busy_o[1]), 64'd0);
        check("t5_long_wd_busy", 64'(busy_o[0]), 64'd1);
        step();
        #1;
        check("t5_next_grant_req1", 64'({ov_o[1], own_o[1]}), 64'd3);
        drv_rdy = 1'b1;
        drv_delay = 3;
        wait_idle("t5");

        // Asynchronous reset while waiting for completion.
        do_reset();
        rq_type[0] = FLASH_OP_WRITE; rq_addr[0] = 24'h000500; rq_bn[0] = 9'd16; rq_vld[0] = 1'b1;
        drv_delay = 15;
        wait_accept("t6", own, ok);
        repeat (3) step();
        #1;
        check("t6_busy_pre", 64'(busy_o[0]), 64'd1);
        #40;
        i_rst_n = 1'b0;
        #1;
        check_all_zero("t6_rst");
        clear_inputs();
        model_init();
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        rq_vld[0] = 1'b1; rq_vld[1] = 1'b1;
        wait_accept("t6_post", own, ok);
        check("t6_first_grant", 64'(own), 64'd0);

        // Randomised traffic against the model on both instances.
        do_reset();
        rnd = 1'b1;
        repeat (2500) step();
        rnd = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/flash_op_arbiter.md
Name: flash_op_arbiter

Overview:
- Two-requester round-robin arbiter in front of the single SPI flash driver's operation/write/read interface, in the 5 MHz PLL clock domain.
- Grants one requester exclusive ownership from operation handshake through operation completion.
- While granted, forwards that requester's operation fields and write stream to the driver, and routes the driver's read stream back to it.
- Sits between user-side generators (data generator, status/config poller) and the flash driver.

Parameters:
- P_DATA_WIDTH, 8: width of write/read data buses.
- P_TIMEOUT, 24'hFFFFFF: watchdog limit in clock cycles for one owned operation (~3.3 s at 5 MHz, covers sector erase).

Ports:
- i_clk  in  1  5 MHz system clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_reqN_op_type / i_reqN_op_addr / i_reqN_op_byte_num  in  2/24/9  operation fields from requester N (N = 0, 1).
- i_reqN_op_valid  in  1  operation request from requester N; held with fields stable until ready.
- o_reqN_op_ready  out  1  operation accepted by the driver for requester N.
- i_reqN_write_data / i_reqN_write_sop / i_reqN_write_eop / i_reqN_write_valid  in  P_DATA_WIDTH/1/1/1  write stream from requester N.
- o_reqN_read_data / o_reqN_read_sop / o_reqN_read_eop / o_reqN_read_valid  out  P_DATA_WIDTH/1/1/1  read stream to requester N.
- o_operation_type / o_operation_addr / o_operation_byte_num  out  2/24/9  operation fields to the driver.
- o_operation_valid  out  1  operation request to the driver.
- i_operation_ready  in  1  driver idle / accept.
- o_write_data / o_write_sop / o_write_eop / o_write_valid  out  P_DATA_WIDTH/1/1/1  write stream to the driver.
- i_read_data / i_read_sop / i_read_eop / i_read_valid  in  P_DATA_WIDTH/1/1/1  read stream from the driver.
- o_owner  out  1  index of the current / last granted requester.
- o_busy  out  1  high in any state other than IDLE.
- o_op_done  out  1  one-cycle pulse on normal completion.
- o_timeout  out  1  one-cycle pulse on watchdog expiry.

Behaviour:
Reset (async, i_rst_n = 0):
- State goes to IDLE; timeout counter = 0; last_grant = 1, so requester 0 wins the first tie.
- o_owner = 0; every other output = 0.

State IDLE:
- If any i_reqN_op_valid: owner = requester that is valid and not last_grant when both are valid, otherwise the one that is valid. Go to GRANT.
- Latency: request sampled at cycle t gives o_operation_valid = 1 at t+1.

State GRANT:
- o_operation_valid = i_{owner}_op_valid. Operation fields are muxed combinationally from the owner.
- o_req{owner}_op_ready = i_operation_ready & i_{owner}_op_valid; the non-owner's ready = 0.
- On valid & ready: go to WAIT_LOW and clear the counter.
- If the owner drops valid before acceptance: return to IDLE. No op_done; last_grant unchanged.
- The non-owner's request waits; it is never dropped by the arbiter.

State WAIT_LOW:
- Wait for i_operation_ready = 0, then go to WAIT_DONE.

State WAIT_DONE:
- Wait for i_operation_ready = 1. Then go to IDLE, pulse o_op_done, and set last_grant = owner.

Watchdog (WAIT_LOW and WAIT_DONE):
- Counter increments every cycle in these states.
- When counter == P_TIMEOUT - 1: go to IDLE, pulse o_timeout, set last_grant = owner, clear the counter.
- If completion and expiry occur in the same cycle, completion wins (o_op_done only).

Write routing:
- In GRANT, WAIT_LOW and WAIT_DONE: o_write_* = owner's i_write_*.
- In IDLE: o_write_valid/sop/eop = 0 and o_write_data = 0.
- The non-owner's write inputs are ignored, with no buffering.

Read routing:
- o_reqN_read_data = i_read_data broadcast to both requesters.
- o_reqN_read_valid/sop/eop = driver signal AND (owner == N) AND state is WAIT_LOW or WAIT_DONE.
- In IDLE all read strobes are 0.

General:
- No combinational path from i_operation_ready to o_operation_valid.
- No data storage; the only state is FSM, owner, last_grant and counter.

Decomposition:
- Shared package `flash_pkg`: operation type constants FLASH_OP_READ = 2'd0, FLASH_OP_WRITE = 2'd1, FLASH_OP_ERASE = 2'd2; address width 24; byte-count width 9; FSM state encoding.
- Sub-module `rr_arb2`: two-input round-robin pick from (valid0, valid1, last_grant), producing grant index and grant_valid. The FSM, muxes and watchdog stay in the top.

Test Plan:
- Reset release, req0 erase at addr 24'h001000, driver model drops ready 1 cycle after accept and raises it 20 cycles later -> o_operation_valid at t+1 with addr 24'h001000; o_op_done pulses once; o_owner = 0; o_busy low after completion.
- req0 and req1 both valid in the same cycle, three back-to-back rounds -> grants alternate 0, 1, 0; each requester's ready asserts only while it owns the grant.
- req1 read of 4 bytes while req0 holds its request, driver returns 8'hA5, 8'h5A, 8'h3C, 8'hC3 -> only o_req1_read_valid toggles, with sop on 8'hA5 and eop on 8'hC3; o_req0_read_valid stays 0.
- req0 page write of 2 bytes 8'h11, 8'h22, with req1 driving write_valid with 8'hFF concurrently -> driver sees only 8'h11 and 8'h22.
- P_TIMEOUT = 16, driver never raises ready after accept -> o_timeout pulses exactly 16 cycles after leaving GRANT; a pending req1 is granted next.
- Assert i_rst_n low during WAIT_DONE -> all outputs 0 immediately; after release, first grant goes to req0.
